// File: rtl/rom_dl_pkg.sv
// Shared types for the ROM download arbiter: arbiter/mode state enums and
// the default core-reset hold time after a ROM load.
package rom_dl_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WRITE = 2'd1,
        ARB_READ  = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        MODE_LOAD    = 2'd0,
        MODE_RELEASE = 2'd1,
        MODE_RUN     = 2'd2
    } mode_t;

    localparam int RELEASE_CYCLES_DEF = 16;

endpackage

// File: rtl/rom_dl_fifo.sv
// Download write buffer: synchronous FIFO of {addr, data} entries.
// A push while full is dropped even if a pop happens in the same cycle.
module rom_dl_fifo #(
    parameter int AW    = 17,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      push,
    input  logic                      pop,
    input  logic [AW-1:0]             push_addr,
    input  logic [DW-1:0]             push_data,
    output logic [AW-1:0]             pop_addr,
    output logic [DW-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW+DW-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign {pop_addr, pop_data} = mem_q[rd_ptr_q];

    // Next pointer and occupancy; simultaneous push/pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer/count state; reset empties the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Entry storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= {push_addr, push_data};
    end

endmodule

// File: rtl/rom_dl_arbiter.sv
// Shares the single-port ROM RAM between the HPS download stream and the
// core's read port. Buffered downloads beat reads; the core is held in
// reset during a load and for RELEASE_CYCLES afterwards.
module rom_dl_arbiter
    import rom_dl_pkg::*;
#(
    parameter int AW             = 17,
    parameter int DW             = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int RD_LAT         = 1,
    parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          dl_active,
    input  logic          dl_wr,
    input  logic [7:0]    dl_index,
    input  logic [23:0]   dl_addr,
    input  logic [7:0]    dl_data,
    output logic          dl_wait,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout,
    output logic          core_reset_n,
    output logic          dl_done,
    output logic          err_ovf
);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int RCW = $clog2(RELEASE_CYCLES + 2);

    logic          accept;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] fifo_addr;
    logic [DW-1:0] fifo_data;

    arb_state_t    arb_q, arb_d;
    mode_t         mode_q, mode_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          mem_we_q, mem_we_d;
    logic [DW-1:0] mem_din_q, mem_din_d;
    logic [1:0]    lat_q, lat_d;
    logic          rd_ack_q, rd_ack_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic [RCW-1:0] rel_q, rel_d;
    logic          dl_done_q, dl_done_d;
    logic          err_ovf_q, err_ovf_d;

    // Only index 0 and in-range addresses belong to the ROM image.
    assign accept = dl_wr && (dl_index == 8'd0) && ((dl_addr >> AW) == 24'd0);

    rom_dl_fifo #(.AW(AW), .DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_sys),
        .rst_n     (reset_n),
        .push      (accept),
        .pop       (fifo_pop),
        .push_addr (dl_addr[AW-1:0]),
        .push_data (DW'(dl_data)),
        .pop_addr  (fifo_addr),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // One slot of margin for a strobe already in flight from the HPS.
    assign dl_wait      = (fifo_count >= CW'(FIFO_DEPTH - 1));
    assign core_reset_n = (mode_q == MODE_RUN);
    assign mem_addr     = mem_addr_q;
    assign mem_we       = mem_we_q;
    assign mem_din      = mem_din_q;
    assign rd_ack       = rd_ack_q;
    assign rd_data      = rd_data_q;
    assign dl_done      = dl_done_q;
    assign err_ovf      = err_ovf_q;

    // Arbiter: queued writes win in IDLE; a read owns the RAM until its data returns.
    always_comb begin
        arb_d      = arb_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = 1'b0;
        mem_din_d  = mem_din_q;
        lat_d      = lat_q;
        rd_ack_d   = 1'b0;
        rd_data_d  = rd_data_q;
        fifo_pop   = 1'b0;
        case (arb_q)
            ARB_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    mem_addr_d = fifo_addr;
                    mem_din_d  = fifo_data;
                    mem_we_d   = 1'b1;
                    arb_d      = ARB_WRITE;
                end else if (rd_req && !rd_ack_q) begin
                    // A request still high in the ack cycle is the old one.
                    mem_addr_d = rd_addr;
                    lat_d      = 2'(RD_LAT);
                    arb_d      = ARB_READ;
                end
            end
            ARB_WRITE: arb_d = ARB_IDLE;
            ARB_READ: begin
                if (lat_q == 2'd0) begin
                    rd_data_d = mem_dout;
                    rd_ack_d  = 1'b1;
                    arb_d     = ARB_IDLE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            default: arb_d = ARB_IDLE;
        endcase
    end

    // Mode: load holds the core, commit when drained, then count down to run.
    always_comb begin
        mode_d    = mode_q;
        rel_d     = rel_q;
        dl_done_d = 1'b0;
        err_ovf_d = err_ovf_q | (accept && fifo_full);
        if (dl_active) begin
            mode_d = MODE_LOAD;
        end else begin
            case (mode_q)
                MODE_LOAD: begin
                    if (fifo_empty && !accept && arb_q != ARB_WRITE) begin
                        mode_d    = MODE_RELEASE;
                        rel_d     = RCW'(RELEASE_CYCLES);
                        dl_done_d = 1'b1;
                    end
                end
                MODE_RELEASE: begin
                    if (rel_q == '0) mode_d = MODE_RUN;
                    else             rel_d  = rel_q - RCW'(1);
                end
                MODE_RUN: mode_d = MODE_RUN;
                default:  mode_d = MODE_RELEASE;
            endcase
        end
    end

    // State registers; reset aborts any access and restarts the release hold.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            arb_q      <= ARB_IDLE;
            mode_q     <= MODE_RELEASE;
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            lat_q      <= '0;
            rd_ack_q   <= 1'b0;
            rd_data_q  <= '0;
            rel_q      <= RCW'(RELEASE_CYCLES);
            dl_done_q  <= 1'b0;
            err_ovf_q  <= 1'b0;
        end else begin
            arb_q      <= arb_d;
            mode_q     <= mode_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            lat_q      <= lat_d;
            rd_ack_q   <= rd_ack_d;
            rd_data_q  <= rd_data_d;
            rel_q      <= rel_d;
            dl_done_q  <= dl_done_d;
            err_ovf_q  <= err_ovf_d;
        end
    end

endmodule
